ysyx_22050019_bus_arbiter: RTL and testbench

//  Round-robin arbiter sharing one memory/bus slave between NR_REQ requesters (IFU, LSU, ...).

---
 rtl/ysyx_22050019_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ysyx_22050019_bus_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050019_bus_arbiter.sv
// ysyx_22050019_bus_arbiter
// Round-robin arbiter that shares one bus slave between NR_REQ requesters.
// One transaction is outstanding at a time: arbitrate (IDLE), forward the
// request (REQ), route the single response beat back (RESP), then re-arbitrate.
// The requester that just completed becomes lowest priority for the next round.

module ysyx_22050019_bus_arbiter #(
    parameter int NR_REQ = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic [NR_REQ-1:0]            s_req_valid,
    output logic [NR_REQ-1:0]            s_req_ready,
    input  logic [NR_REQ*ADDR_W-1:0]     s_req_addr,
    input  logic [NR_REQ-1:0]            s_req_wen,
    input  logic [NR_REQ*DATA_W-1:0]     s_req_wdata,
    input  logic [NR_REQ*(DATA_W/8)-1:0] s_req_wmask,
    output logic [NR_REQ-1:0]            s_resp_valid,
    input  logic [NR_REQ-1:0]            s_resp_ready,
    output logic [DATA_W-1:0]            s_resp_rdata,

    output logic                         m_req_valid,
    input  logic                         m_req_ready,
    output logic [ADDR_W-1:0]            m_req_addr,
    output logic                         m_req_wen,
    output logic [DATA_W-1:0]            m_req_wdata,
    output logic [DATA_W/8-1:0]          m_req_wmask,
    input  logic                         m_resp_valid,
    output logic                         m_resp_ready,
    input  logic [DATA_W-1:0]            m_resp_rdata,

    output logic [IDX_W-1:0]             grant_idx
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;

    // Arbitration result for the current IDLE cycle.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Pointer value that makes the just-finished owner lowest priority.
    logic [IDX_W-1:0] next_ptr;

    // Fields of the currently granted requester.
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wen;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_wmask;

    // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        hi_found  = 1'b0;
        hi_idx    = '0;
        arb_found = 1'b0;
        lo_idx    = '0;
        for (int n = NR_REQ - 1; n >= 0; n--) begin
            if (s_req_valid[n]) begin
                arb_found = 1'b1;
                lo_idx    = IDX_W'(n);
                if (IDX_W'(n) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(n);
                end
            end
        end
        arb_idx = hi_found ? hi_idx : lo_idx;
    end

    // Wrap grant_idx+1 back to requester 0 after the last one.
    always_comb begin
        if (grant_idx == IDX_W'(NR_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_idx + IDX_W'(1);
        end
    end

    // Key-select the granted requester's request fields out of the flattened buses.
    always_comb begin
        sel_addr  = '0;
        sel_wen   = 1'b0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int n = 0; n < NR_REQ; n++) begin
            if (grant_idx == IDX_W'(n)) begin
                sel_addr  = s_req_addr[n*ADDR_W +: ADDR_W];
                sel_wen   = s_req_wen[n];
                sel_wdata = s_req_wdata[n*DATA_W +: DATA_W];
                sel_wmask = s_req_wmask[n*MASK_W +: MASK_W];
            end
        end
    end

    // Transaction FSM: owns state, round-robin pointer and the registered grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        grant_idx <= arb_idx;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A requester withdrawing before the handshake forfeits its turn
                    // without moving the pointer.
                    if (!s_req_valid[grant_idx]) begin
                        state <= ST_IDLE;
                    end else if (m_req_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_resp_valid && s_resp_ready[grant_idx]) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake routing: only the owner sees ready/valid, and only in its phase.
    always_comb begin
        s_req_ready  = '0;
        s_resp_valid = '0;
        s_resp_rdata = '0;
        m_req_valid  = 1'b0;
        m_req_addr   = '0;
        m_req_wen    = 1'b0;
        m_req_wdata  = '0;
        m_req_wmask  = '0;
        m_resp_ready = 1'b0;
        case (state)
            ST_REQ: begin
                m_req_valid            = s_req_valid[grant_idx];
                m_req_addr             = sel_addr;
                m_req_wen              = sel_wen;
                m_req_wdata            = sel_wdata;
                m_req_wmask            = sel_wmask;
                s_req_ready[grant_idx] = m_req_ready;
            end
            ST_RESP: begin
                m_resp_ready            = s_resp_ready[grant_idx];
                s_resp_valid[grant_idx] = m_resp_valid;
                s_resp_rdata            = m_resp_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050019_bus_arbiter.sv
// tb_ysyx_22050019_bus_arbiter
// Self-checking bench: the bench plays both the requesters and the slave, and
// predicts every grant from a round-robin reference kept as a plain integer.

module tb_ysyx_22050019_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;
    localparam int IW = 1;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    s_req_valid;
    logic [N-1:0]    s_req_ready;
    logic [N*AW-1:0] s_req_addr;
    logic [N-1:0]    s_req_wen;
    logic [N*DW-1:0] s_req_wdata;
    logic [N*MW-1:0] s_req_wmask;
    logic [N-1:0]    s_resp_valid;
    logic [N-1:0]    s_resp_ready;
    logic [DW-1:0]   s_resp_rdata;
    logic            m_req_valid;
    logic            m_req_ready;
    logic [AW-1:0]   m_req_addr;
    logic            m_req_wen;
    logic [DW-1:0]   m_req_wdata;
    logic [MW-1:0]   m_req_wmask;
    logic            m_resp_valid;
    logic            m_resp_ready;
    logic [DW-1:0]   m_resp_rdata;
    logic [IW-1:0]   grant_idx;

    int checks   = 0;
    int failures = 0;
    int rr_model = 0;   // requester that has top priority at the next arbitration
    int last_g   = -1;  // requester granted by the most recent transaction

    ysyx_22050019_bus_arbiter #(
        .NR_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_addr(s_req_addr), .s_req_wen(s_req_wen),
        .s_req_wdata(s_req_wdata), .s_req_wmask(s_req_wmask),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_rdata(s_resp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
        .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
        .m_resp_rdata(m_resp_rdata),
        .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first requesting index walking up from rr, modulo N.
    function automatic int exp_grant(input int rr, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_req_ready"},  s_req_ready,  0);
        chk({tag, "_s_resp_valid"}, s_resp_valid, 0);
        chk({tag, "_s_resp_rdata"}, s_resp_rdata, 0);
        chk({tag, "_m_req_valid"},  m_req_valid,  0);
        chk({tag, "_m_req_addr"},   m_req_addr,   0);
        chk({tag, "_m_req_wen"},    m_req_wen,    0);
        chk({tag, "_m_req_wdata"},  m_req_wdata,  0);
        chk({tag, "_m_req_wmask"},  m_req_wmask,  0);
        chk({tag, "_m_resp_ready"}, m_resp_ready, 0);
        chk({tag, "_grant_idx"},    grant_idx,    0);
    endtask

    // One complete transaction from IDLE, with the granted requester's fields given.
    // drop=1 withdraws the request instead of handshaking on the last REQ cycle.
    task automatic run_txn(input logic [N-1:0] mask, input logic [AW-1:0] addr,
                           input logic wen, input logic [DW-1:0] wdata,
                           input logic [MW-1:0] wmask, input logic [DW-1:0] rdata,
                           input int rdy_delay, input int resp_hold, input bit drop);
        int g;
        logic [N-1:0] onehot;
        g      = exp_grant(rr_model, mask);
        onehot = N'(1) << g;
        for (int n = 0; n < N; n++) begin
            s_req_addr[n*AW +: AW]  = $urandom;
            s_req_wen[n]            = 1'($urandom);
            s_req_wdata[n*DW +: DW] = {$urandom, $urandom};
            s_req_wmask[n*MW +: MW] = MW'($urandom);
        end
        s_req_addr[g*AW +: AW]  = addr;
        s_req_wen[g]            = wen;
        s_req_wdata[g*DW +: DW] = wdata;
        s_req_wmask[g*MW +: MW] = wmask;
        s_req_valid  = mask;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'($urandom);   // stray slave responses must be ignored
        m_resp_rdata = {$urandom, $urandom};
        s_resp_ready = '1;
        #1;
        chk("idle_m_req_valid",  m_req_valid,  0);
        chk("idle_s_req_ready",  s_req_ready,  0);
        chk("idle_m_resp_ready", m_resp_ready, 0);
        chk("idle_s_resp_valid", s_resp_valid, 0);
        tick();
        chk("grant_idx", grant_idx, g);
        for (int c = 0; c <= rdy_delay; c++) begin
            if (c == rdy_delay) begin
                if (drop) s_req_valid = mask & ~onehot;
                else      m_req_ready = 1'b1;
            end
            m_resp_valid = 1'($urandom);
            #1;
            chk("req_m_resp_ready", m_resp_ready, 0);
            chk("req_s_resp_valid", s_resp_valid, 0);
            if (drop && c == rdy_delay) begin
                chk("drop_m_req_valid", m_req_valid, 0);
                chk("drop_s_req_ready", s_req_ready, 0);
            end else begin
                chk("req_m_req_valid", m_req_valid, 1);
                chk("req_m_req_addr",  m_req_addr,  addr);
                chk("req_m_req_wen",   m_req_wen,   wen);
                chk("req_m_req_wdata", m_req_wdata, wdata);
                chk("req_m_req_wmask", m_req_wmask, wmask);
                chk("req_s_req_ready", s_req_ready, m_req_ready ? onehot : '0);
            end
            tick();
        end
        if (drop) begin
            s_req_valid  = '0;
            m_resp_valid = 1'b0;
            return;
        end
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = rdata;
        for (int c = 0; c <= resp_hold; c++) begin
            s_resp_ready = (c == resp_hold) ? '1 : ~onehot;
            #1;
            chk("resp_s_req_ready",  s_req_ready,  0);
            chk("resp_m_req_valid",  m_req_valid,  0);
            chk("resp_s_resp_valid", s_resp_valid, onehot);
            chk("resp_s_resp_rdata", s_resp_rdata, rdata);
            chk("resp_m_resp_ready", m_resp_ready, (c == resp_hold) ? 1 : 0);
            chk("resp_grant_idx",    grant_idx,    g);
            tick();
        end
        m_resp_valid = 1'b0;
        s_req_valid  = '0;
        rr_model     = (g + 1) % N;
        last_g       = g;
    endtask

    int t2_order [4] = '{0, 1, 0, 1};

    initial begin
        rst_n        = 1'b0;
        s_req_valid  = '0;
        s_req_addr   = '0;
        s_req_wen    = '0;
        s_req_wdata  = '0;
        s_req_wmask  = '0;
        s_resp_ready = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_rdata = '0;
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Two persistent requesters alternate, starting from requester 0.
        for (int i = 0; i < 4; i++) begin
            run_txn(2'b11, $urandom, 1'b0, {$urandom, $urandom}, 8'hFF,
                    {$urandom, $urandom}, 0, 0, 1'b0);
            chk("t2_order", last_g, t2_order[i]);
        end

        // Lone read from requester 0, slave ready at once.
        run_txn(2'b01, 32'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h1234, 0, 0, 1'b0);
        chk("t1_grant", last_g, 0);

        // Slave stalls the request for three cycles.
        run_txn(2'b01, 32'h0000_1000, 1'b0, 64'h0, 8'h00, 64'h55AA, 3, 0, 1'b0);

        // Requester 1 stalls the response for two cycles.
        run_txn(2'b10, 32'h0000_2000, 1'b0, 64'h0, 8'h00, 64'hCAFE, 0, 2, 1'b0);

        // Write from requester 1.
        run_txn(2'b10, 32'h0000_3000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'h0, 0, 0, 1'b0);

        // Withdrawn request leaves the pointer alone: same owner wins again.
        run_txn(2'b11, $urandom, 1'b0, 64'h0, 8'h00, 64'h0, 1, 0, 1'b1);
        run_txn(2'b11, $urandom, 1'b0, 64'h0, 8'h00, 64'h77, 0, 0, 1'b0);
        chk("drop_keeps_ptr", last_g, 0);

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            run_txn(N'($urandom_range(1, (1 << N) - 1)), $urandom, 1'($urandom),
                    {$urandom, $urandom}, MW'($urandom), {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 5) == 0));
        end

        // Reset while requester 1 owns the bus in RESP.
        s_req_valid  = 2'b10;
        s_req_addr   = {N{32'hABCD_0000}};
        s_resp_ready = '0;
        m_req_ready  = 1'b1;
        tick();
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_rdata = 64'h9999;
        #1;
        chk("t6_in_resp", s_resp_valid, 2'b10);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        s_req_valid  = '0;
        m_resp_valid = 1'b0;
        s_resp_ready = '1;
        tick();
        rst_n    = 1'b1;
        rr_model = 0;
        tick();
        run_txn(2'b11, $urandom, 1'b0, 64'h0, 8'h00, 64'h42, 0, 0, 1'b0);
        chk("t6_restart_grant", last_g, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
